pipeline_mem_arbiter: RTL

Shares one single-port, variable-latency memory between the pipelined CPU's instruction-fetch port (IF stage) and data port (Mem stage). It arbitrates with strict data priority, registers the memory request, waits for the memory acknowledge, and returns a one-cycle ready pulse with the read data. The pipeline derives its stalls from `req & ~ready`. It sits between the CPU core's `inst_IF`/`Data_in`/`Addr_out`/`Data_out`/`MemRW_Mem` signals and the unified memory.

---
 rtl/pipeline_mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_mem_arbiter.sv
// rtl/pipeline_mem_arbiter.sv - data-priority arbiter sharing one memory between fetch and data ports
// Optional one-entry fetch buffer enabled by defining ARB_FETCH_BUF_EN.
module pipeline_mem_arbiter #(
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_mem_req, r_mem_we, r_if_ready, r_d_ready, r_timeout_err;
    logic [31:0] r_mem_addr, r_mem_wdata, r_if_inst, r_d_rdata;
    logic        w_d_ok, w_i_ok, w_timeout, w_busy;
    logic        w_grant_d, w_grant_i, w_buf_serve, w_buf_hit;
    logic [31:0] w_buf_inst;

    // A requester whose ready is high this cycle is still holding the completed request.
    assign w_d_ok    = d_req & ~r_d_ready;
    assign w_i_ok    = if_req & ~r_if_ready;
    assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_timeout = ~mem_ack && (r_cnt == TO_LAST);

`ifdef ARB_FETCH_BUF_EN
    logic        r_buf_valid;
    logic [31:0] r_buf_addr, r_buf_inst;

    assign w_buf_hit  = r_buf_valid && (r_buf_addr == if_addr);
    assign w_buf_inst = r_buf_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_inst  <= '0;
        end else if ((r_state == BUSY_I) && mem_ack) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= r_mem_addr;
            r_buf_inst  <= mem_rdata;
        end else if (w_grant_d && d_we) begin
            r_buf_valid <= 1'b0;
        end
    end
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_inst = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_buf_serve = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_ok) begin
                    w_next    = BUSY_D;
                    w_grant_d = 1'b1;
                end else if (w_i_ok) begin
                    if (w_buf_hit) begin
                        w_buf_serve = 1'b1;
                    end else begin
                        w_next    = BUSY_I;
                        w_grant_i = 1'b1;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || w_timeout) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_inst     <= '0;
            r_d_rdata     <= '0;
            r_if_ready    <= 1'b0;
            r_d_ready     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_cnt       <= '0;
            end else if (w_grant_i) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
                r_cnt       <= '0;
            end else if (w_buf_serve) begin
                r_if_ready <= 1'b1;
                r_if_inst  <= w_buf_inst;
            end
            if (w_busy) begin
                if (mem_ack || w_timeout) begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    if (r_state == BUSY_I) begin
                        r_if_ready <= 1'b1;
                        r_if_inst  <= mem_ack ? mem_rdata : NOP_INST;
                    end else begin
                        r_d_ready <= 1'b1;
                        r_d_rdata <= mem_ack ? mem_rdata : 32'h0;
                    end
                    if (!mem_ack) r_timeout_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign if_inst     = r_if_inst;
    assign if_ready    = r_if_ready;
    assign d_rdata     = r_d_rdata;
    assign d_ready     = r_d_ready;
    assign timeout_err = r_timeout_err;
endmodule
